exe_stage: RTL and testbench

- Execute stage: consumes the ID/EXE pipeline-register fields, computes the ALU result, and registers result plus pass-through control into EXE/MEM outputs.
- Single-cycle ops complete in one clock.
- MUL/DIV/REM run on a 16-iteration shift/subtract engine. The block raises exo_stall_req so upstream holds the ID/EXE fields stable.
- Opcode 0x00 with `REG_INVALID`/`RWE_IDLE` (defines.v) is a bubble.

---
 rtl/exe_stage.sv | 218 +++++++++++++++++++++
 tb/tb_exe_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: ALU plus EXE/MEM output register. Define EXE_MULDIV_EN to add
// the 16-iteration shift/subtract engine for MUL/DIV/REM (otherwise those opcodes are illegal).

`ifndef REG_INVALID
`define REG_INVALID 4'h0
`endif
`ifndef RWE_IDLE
`define RWE_IDLE 2'b00
`endif

module exe_stage #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic              iei_clk,
  input  logic              iei_rst,
  input  logic              iei_flush,
  input  logic [15:0]       iei_instr,
  input  logic [15:0]       iei_pc,
  input  logic [7:0]        iei_alu_opcode,
  input  logic [DATA_W-1:0] iei_op1,
  input  logic [DATA_W-1:0] iei_op2,
  input  logic [3:0]        iei_wreg_addr,
  input  logic [DATA_W-1:0] iei_write_to_mem_data,
  input  logic [1:0]        iei_rwe,
  output logic [15:0]       exo_instr,
  output logic [15:0]       exo_pc,
  output logic [DATA_W-1:0] exo_result,
  output logic [3:0]        exo_wreg_addr,
  output logic [DATA_W-1:0] exo_write_to_mem_data,
  output logic [1:0]        exo_rwe,
  output logic              exo_stall_req,
  output logic              exo_illegal
);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_AND  = 8'h03;
  localparam logic [7:0] OP_OR   = 8'h04;
  localparam logic [7:0] OP_XOR  = 8'h05;
  localparam logic [7:0] OP_NOT  = 8'h06;
  localparam logic [7:0] OP_SLL  = 8'h07;
  localparam logic [7:0] OP_SRL  = 8'h08;
  localparam logic [7:0] OP_SRA  = 8'h09;
  localparam logic [7:0] OP_SLT  = 8'h0A;
  localparam logic [7:0] OP_SLTU = 8'h0B;
  localparam logic [7:0] OP_MOVE = 8'h0C;
  localparam logic [7:0] OP_MUL  = 8'h10;
  localparam logic [7:0] OP_DIV  = 8'h11;
  localparam logic [7:0] OP_REM  = 8'h12;

  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  alu_result;
  logic               op_legal;
  logic               op_nop;
  logic               op_multi;
  logic               load_alu;
  logic               load_md;
  logic               flag_illegal;
  logic [DATA_W-1:0]  out_result;

  assign shamt = iei_op2[SHAMT_W-1:0];

  always_comb begin
    alu_result = '0;
    op_legal   = 1'b1;
    op_nop     = 1'b0;
    op_multi   = 1'b0;
    case (iei_alu_opcode)
      OP_NOP:  op_nop = 1'b1;
      OP_ADD:  alu_result = iei_op1 + iei_op2;
      OP_SUB:  alu_result = iei_op1 - iei_op2;
      OP_AND:  alu_result = iei_op1 & iei_op2;
      OP_OR:   alu_result = iei_op1 | iei_op2;
      OP_XOR:  alu_result = iei_op1 ^ iei_op2;
      OP_NOT:  alu_result = ~iei_op1;
      OP_SLL:  alu_result = iei_op1 << shamt;
      OP_SRL:  alu_result = iei_op1 >> shamt;
      OP_SRA:  alu_result = $signed(iei_op1) >>> shamt;
      OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, $signed(iei_op1) < $signed(iei_op2)};
      OP_SLTU: alu_result = {{(DATA_W-1){1'b0}}, iei_op1 < iei_op2};
      OP_MOVE: alu_result = iei_op2;
`ifdef EXE_MULDIV_EN
      OP_MUL, OP_DIV, OP_REM: op_multi = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

`ifdef EXE_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;
  localparam logic [1:0] MD_MUL = 2'd0;
  localparam logic [1:0] MD_DIV = 2'd1;

  state_t            state, state_next;
  logic [3:0]        count, count_next;
  logic [1:0]        md_op, md_op_next;
  logic [DATA_W-1:0] md_a, md_a_next;
  logic [DATA_W-1:0] md_b, md_b_next;
  logic [DATA_W-1:0] md_acc, md_acc_next;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   trial_sub;
  logic              md_ge;

  always_ff @(posedge iei_clk or negedge iei_rst) begin
    if (!iei_rst) begin
      state  <= IDLE;
      count  <= '0;
      md_op  <= MD_MUL;
      md_a   <= '0;
      md_b   <= '0;
      md_acc <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      md_op  <= md_op_next;
      md_a   <= md_a_next;
      md_b   <= md_b_next;
      md_acc <= md_acc_next;
    end
  end

  // MUL: md_a is the shifting multiplicand, md_b the shifting multiplier, md_acc the product.
  // DIV/REM: md_a is the divisor, md_b shifts dividend bits out and quotient bits in,
  // md_acc is the partial remainder. A zero divisor naturally yields 0xFFFF / op1.
  always_comb begin
    state_next    = state;
    count_next    = count;
    md_op_next    = md_op;
    md_a_next     = md_a;
    md_b_next     = md_b;
    md_acc_next   = md_acc;
    exo_stall_req = 1'b0;
    trial         = {md_acc, md_b[DATA_W-1]};
    trial_sub     = trial - {1'b0, md_a};
    md_ge         = (trial >= {1'b0, md_a});
    case (state)
      IDLE: begin
        if (op_multi) begin
          exo_stall_req = 1'b1;
          state_next    = BUSY;
          count_next    = '0;
          md_op_next    = iei_alu_opcode[1:0];
          md_acc_next   = '0;
          if (iei_alu_opcode == OP_MUL) begin
            md_a_next = iei_op1;
            md_b_next = iei_op2;
          end else begin
            md_a_next = iei_op2;
            md_b_next = iei_op1;
          end
        end
      end
      BUSY: begin
        exo_stall_req = 1'b1;
        count_next    = count + 4'd1;
        if (count == 4'd15) state_next = FINISH;
        if (md_op == MD_MUL) begin
          md_acc_next = md_acc + (md_b[0] ? md_a : '0);
          md_a_next   = md_a << 1;
          md_b_next   = md_b >> 1;
        end else begin
          md_acc_next = md_ge ? trial_sub[DATA_W-1:0] : trial[DATA_W-1:0];
          md_b_next   = {md_b[DATA_W-2:0], md_ge};
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (iei_flush) begin
      state_next = IDLE;
      count_next = '0;
    end
  end

  assign load_alu     = (state == IDLE) && op_legal && !op_nop && !op_multi;
  assign load_md      = (state == FINISH);
  assign flag_illegal = (state == IDLE) && !op_legal;
  assign out_result   = load_md ? ((md_op == MD_DIV) ? md_b : md_acc) : alu_result;
`else
  assign exo_stall_req = 1'b0;
  assign load_alu      = op_legal && !op_nop;
  assign load_md       = 1'b0;
  assign flag_illegal  = !op_legal;
  assign out_result    = alu_result;
`endif

  // Anything that is not a completed operation leaves a bubble in EXE/MEM.
  always_ff @(posedge iei_clk or negedge iei_rst) begin
    if (!iei_rst) begin
      exo_instr             <= '0;
      exo_pc                <= '0;
      exo_result            <= '0;
      exo_wreg_addr         <= `REG_INVALID;
      exo_write_to_mem_data <= '0;
      exo_rwe               <= `RWE_IDLE;
      exo_illegal           <= 1'b0;
    end else if (!iei_flush && (load_alu || load_md)) begin
      exo_instr             <= iei_instr;
      exo_pc                <= iei_pc;
      exo_result            <= out_result;
      exo_wreg_addr         <= iei_wreg_addr;
      exo_write_to_mem_data <= iei_write_to_mem_data;
      exo_rwe               <= iei_rwe;
      exo_illegal           <= 1'b0;
    end else begin
      exo_instr             <= '0;
      exo_pc                <= '0;
      exo_result            <= '0;
      exo_wreg_addr         <= `REG_INVALID;
      exo_write_to_mem_data <= '0;
      exo_rwe               <= `RWE_IDLE;
      exo_illegal           <= !iei_flush && flag_illegal;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed table, random vectors against an
// arithmetic reference model, and multi-cycle/flush/reset sequences (EXE_MULDIV_EN aware).

`ifndef REG_INVALID
`define REG_INVALID 4'h0
`endif
`ifndef RWE_IDLE
`define RWE_IDLE 2'b00
`endif

module tb_exe_stage;

  logic        iei_clk = 1'b0;
  logic        iei_rst = 1'b0;
  logic        iei_flush = 1'b0;
  logic [15:0] iei_instr = '0;
  logic [15:0] iei_pc = '0;
  logic [7:0]  iei_alu_opcode = '0;
  logic [15:0] iei_op1 = '0;
  logic [15:0] iei_op2 = '0;
  logic [3:0]  iei_wreg_addr = `REG_INVALID;
  logic [15:0] iei_write_to_mem_data = '0;
  logic [1:0]  iei_rwe = `RWE_IDLE;
  logic [15:0] exo_instr;
  logic [15:0] exo_pc;
  logic [15:0] exo_result;
  logic [3:0]  exo_wreg_addr;
  logic [15:0] exo_write_to_mem_data;
  logic [1:0]  exo_rwe;
  logic        exo_stall_req;
  logic        exo_illegal;

  int checks = 0;
  int passes = 0;

  exe_stage dut (
    .iei_clk(iei_clk), .iei_rst(iei_rst), .iei_flush(iei_flush),
    .iei_instr(iei_instr), .iei_pc(iei_pc), .iei_alu_opcode(iei_alu_opcode),
    .iei_op1(iei_op1), .iei_op2(iei_op2), .iei_wreg_addr(iei_wreg_addr),
    .iei_write_to_mem_data(iei_write_to_mem_data), .iei_rwe(iei_rwe),
    .exo_instr(exo_instr), .exo_pc(exo_pc), .exo_result(exo_result),
    .exo_wreg_addr(exo_wreg_addr), .exo_write_to_mem_data(exo_write_to_mem_data),
    .exo_rwe(exo_rwe), .exo_stall_req(exo_stall_req), .exo_illegal(exo_illegal)
  );

  always #5 iei_clk = ~iei_clk;

  typedef struct {
    logic [7:0]  opc;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] res;
    logic        writes;
    logic        ill;
  } vec_t;

  vec_t tbl[$];

  // Reference: {legal, writes, result} from plain integer arithmetic.
  function automatic logic [17:0] refModel(input logic [7:0] opc, input logic [15:0] a, input logic [15:0] b);
    int unsigned ua = a;
    int unsigned ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int unsigned sh = b[3:0];
    logic [15:0] r = '0;
    logic legal = 1'b1;
    logic writes = 1'b1;
    case (opc)
      8'h00: writes = 1'b0;
      8'h01: r = 16'(ua + ub);
      8'h02: r = 16'(ua - ub);
      8'h03: r = a & b;
      8'h04: r = a | b;
      8'h05: r = a ^ b;
      8'h06: r = ~a;
      8'h07: r = 16'(ua * (32'd1 << sh));
      8'h08: r = 16'(ua / (32'd1 << sh));
      8'h09: r = 16'(sa >>> sh);
      8'h0A: r = (sa < sb) ? 16'd1 : 16'd0;
      8'h0B: r = (ua < ub) ? 16'd1 : 16'd0;
      8'h0C: r = b;
`ifdef EXE_MULDIV_EN
      8'h10: r = 16'(ua * ub);
      8'h11: r = (ub == 0) ? 16'hFFFF : 16'(ua / ub);
      8'h12: r = (ub == 0) ? a : 16'(ua % ub);
`endif
      default: begin legal = 1'b0; writes = 1'b0; end
    endcase
    return {legal, writes, r};
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] got, input logic [79:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic applyStimulus(input logic [7:0] opc, input logic [15:0] a, input logic [15:0] b);
    iei_alu_opcode        = opc;
    iei_op1               = a;
    iei_op2               = b;
    iei_instr             = 16'($urandom);
    iei_pc                = 16'($urandom);
    iei_wreg_addr         = 4'($urandom_range(0, 15));
    iei_write_to_mem_data = 16'($urandom);
    iei_rwe               = 2'($urandom_range(0, 3));
  endtask

  task automatic checkStage(input string name, input logic writes, input logic [15:0] res, input logic ill);
    logic [79:0] want;
    if (writes) want = {iei_instr, iei_pc, res, iei_wreg_addr, iei_write_to_mem_data, iei_rwe, 1'b0};
    else        want = {16'h0, 16'h0, 16'h0, `REG_INVALID, 16'h0, `RWE_IDLE, ill};
    checkOutput(name, {exo_instr, exo_pc, exo_result, exo_wreg_addr, exo_write_to_mem_data, exo_rwe, exo_illegal}, want);
  endtask

  task automatic stepCheck(input string name, input logic writes, input logic [15:0] res, input logic ill);
    #1;
    checkOutput({name, " stall"}, 80'(exo_stall_req), 80'(0));
    @(posedge iei_clk); #1;
    checkStage(name, writes, res, ill);
  endtask

`ifdef EXE_MULDIV_EN
  task automatic runMulti(input string name, input logic [7:0] opc, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] res);
    int n = 0;
    applyStimulus(opc, a, b);
    #1;
    while (exo_stall_req && n < 40) begin
      n++;
      @(posedge iei_clk); #1;
      checkOutput({name, " bubble"}, 80'({exo_result, exo_wreg_addr, exo_rwe, exo_illegal}),
                  80'({16'h0, `REG_INVALID, `RWE_IDLE, 1'b0}));
    end
    checkOutput({name, " stall cycles"}, 80'(n), 80'(17));
    @(posedge iei_clk); #1;
    checkStage(name, 1'b1, res, 1'b0);
  endtask
`endif

  initial begin
    logic [17:0] m;
    logic [7:0]  opc;
    logic [15:0] a, b;

    tbl.push_back('{8'h01, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0});
    tbl.push_back('{8'h02, 16'h000A, 16'h0003, 16'h0007, 1'b1, 1'b0});
    tbl.push_back('{8'h02, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0});
    tbl.push_back('{8'h03, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b1, 1'b0});
    tbl.push_back('{8'h04, 16'hF0F0, 16'h0F01, 16'hFFF1, 1'b1, 1'b0});
    tbl.push_back('{8'h05, 16'hFF00, 16'h0FF0, 16'hF0F0, 1'b1, 1'b0});
    tbl.push_back('{8'h06, 16'h00FF, 16'h1234, 16'hFF00, 1'b1, 1'b0});
    tbl.push_back('{8'h07, 16'h0001, 16'h0013, 16'h0008, 1'b1, 1'b0});
    tbl.push_back('{8'h07, 16'h0001, 16'h000F, 16'h8000, 1'b1, 1'b0});
    tbl.push_back('{8'h08, 16'h8000, 16'h0004, 16'h0800, 1'b1, 1'b0});
    tbl.push_back('{8'h09, 16'h8000, 16'h0004, 16'hF800, 1'b1, 1'b0});
    tbl.push_back('{8'h0A, 16'hFFFF, 16'h0001, 16'h0001, 1'b1, 1'b0});
    tbl.push_back('{8'h0B, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{8'h0C, 16'h1111, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0});
    tbl.push_back('{8'h00, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{8'h7F, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1});
    tbl.push_back('{8'h01, 16'h0002, 16'h0003, 16'h0005, 1'b1, 1'b0});
`ifndef EXE_MULDIV_EN
    tbl.push_back('{8'h10, 16'h0123, 16'h0045, 16'h0000, 1'b0, 1'b1});
    tbl.push_back('{8'h11, 16'h0064, 16'h0007, 16'h0000, 1'b0, 1'b1});
    tbl.push_back('{8'h12, 16'h0064, 16'h0007, 16'h0000, 1'b0, 1'b1});
    tbl.push_back('{8'h0C, 16'h0000, 16'h4321, 16'h4321, 1'b1, 1'b0});
`endif

    // Reset state, then release reset away from the clock edge.
    repeat (2) @(posedge iei_clk);
    #1;
    checkStage("reset", 1'b0, 16'h0, 1'b0);
    checkOutput("reset stall", 80'(exo_stall_req), 80'(0));
    iei_rst = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].opc, tbl[i].op1, tbl[i].op2);
      stepCheck($sformatf("vec%0d op%02h", i, tbl[i].opc), tbl[i].writes, tbl[i].res, tbl[i].ill);
    end

    for (int i = 0; i < 150; i++) begin
      opc = 8'($urandom_range(0, 13));
      if (opc == 8'd13) opc = 8'($urandom_range(32, 255));
      a = 16'($urandom);
      b = 16'($urandom);
      m = refModel(opc, a, b);
      applyStimulus(opc, a, b);
      stepCheck($sformatf("rand%0d op%02h", i, opc), m[16], m[15:0], !m[17]);
    end

    // Flush beats a legal op and suppresses the illegal pulse.
    applyStimulus(8'h01, 16'h0004, 16'h0005);
    iei_flush = 1'b1;
    stepCheck("flush add", 1'b0, 16'h0, 1'b0);
    applyStimulus(8'h7F, 16'h0, 16'h0);
    stepCheck("flush illegal", 1'b0, 16'h0, 1'b0);
    iei_flush = 1'b0;

    // Asynchronous reset clears a registered result between edges.
    applyStimulus(8'h01, 16'h0002, 16'h0003);
    stepCheck("pre-reset add", 1'b1, 16'h0005, 1'b0);
    iei_rst = 1'b0;
    #1;
    checkStage("async reset", 1'b0, 16'h0, 1'b0);
    iei_rst = 1'b1;

`ifdef EXE_MULDIV_EN
    runMulti("mul", 8'h10, 16'h0123, 16'h0045, 16'h4E6F);
    runMulti("div", 8'h11, 16'd100, 16'd7, 16'h000E);
    runMulti("rem", 8'h12, 16'd100, 16'd7, 16'h0002);
    runMulti("div0", 8'h11, 16'd5, 16'd0, 16'hFFFF);
    runMulti("rem0", 8'h12, 16'd5, 16'd0, 16'h0005);
    for (int i = 0; i < 6; i++) begin
      opc = 8'($urandom_range(16, 18));
      a = 16'($urandom);
      b = (i == 5) ? 16'h0 : 16'($urandom_range(0, 300));
      m = refModel(opc, a, b);
      runMulti($sformatf("rmd%0d op%02h", i, opc), opc, a, b, m[15:0]);
    end

    // Reset after 5 BUSY cycles.
    applyStimulus(8'h10, 16'h0123, 16'h0045);
    @(posedge iei_clk); #1;
    repeat (5) @(posedge iei_clk);
    #1;
    checkOutput("busy stall", 80'(exo_stall_req), 80'(1));
    iei_rst = 1'b0;
    #1;
    checkOutput("reset busy stall", 80'(exo_stall_req), 80'(0));
    checkStage("reset busy", 1'b0, 16'h0, 1'b0);
    iei_rst = 1'b1;
    applyStimulus(8'h01, 16'h0002, 16'h0003);
    stepCheck("add after reset", 1'b1, 16'h0005, 1'b0);

    // Flush once the iteration count has reached 8.
    applyStimulus(8'h11, 16'd100, 16'd7);
    @(posedge iei_clk); #1;
    repeat (8) @(posedge iei_clk);
    #1;
    applyStimulus(8'h02, 16'd10, 16'd3);
    iei_flush = 1'b1;
    @(posedge iei_clk); #1;
    iei_flush = 1'b0;
    checkStage("flush busy", 1'b0, 16'h0, 1'b0);
    checkOutput("flush busy stall", 80'(exo_stall_req), 80'(0));
    applyStimulus(8'h02, 16'd10, 16'd3);
    stepCheck("sub after flush", 1'b1, 16'h0007, 1'b0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
